stopwatch_lap_ctrl: RTL
=======================

Name: stopwatch_lap_ctrl

Overview:
- Mode and sequencing controller placed between the debounced button pulses and the stopwatch block.
- Issues single-cycle run/stop and clear commands to the stopwatch.
- Captures lap times from the stopwatch time outputs into a small lap buffer.
- Muxes either the live time or a stored lap onto the display path, and lets the user browse stored laps while stopped.

Parameters:
LAP_DEPTH, 4, number of lap entries stored; legal range 2..16.
IDX_W, 2, index width; must equal clog2(LAP_DEPTH).

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
i_btn_runstop  input  1  debounced one-cycle pulse, run/stop button
i_btn_clear  input  1  debounced one-cycle pulse, clear button
i_btn_lap  input  1  debounced one-cycle pulse, lap/browse button
i_msec  input  7  live stopwatch msec (0..99)
i_sec  input  6  live stopwatch sec
i_min  input  6  live stopwatch min
i_hour  input  5  live stopwatch hour
o_runstop  output  1  one-cycle run/stop toggle command to stopwatch
o_clear  output  1  one-cycle clear command to stopwatch
o_disp_msec  output  7  displayed msec
o_disp_sec  output  6  displayed sec
o_disp_min  output  6  displayed min
o_disp_hour  output  5  displayed hour
o_lap_cnt  output  IDX_W+1  number of valid laps (0..LAP_DEPTH)
o_lap_idx  output  IDX_W  lap index currently shown in REVIEW
o_full  output  1  lap_cnt == LAP_DEPTH
o_state  output  2  IDLE=00, RUN=01, STOP=10, REVIEW=11

Behaviour:
Reset (asynchronous, active-high):
- state=IDLE; o_runstop=0; o_clear=0.
- lap_cnt=0; wr_ptr=0; o_lap_idx=0; o_full=0.
- Buffer contents are don't-care.
- Display outputs show the live inputs.
- Reset mid-operation aborts any browse/capture immediately; no command pulse is emitted.

Input priority:
- Inputs are sampled on the rising edge of clk.
- When several buttons pulse in the same cycle: clear > runstop > lap. Only the highest-priority legal action is taken; the others are dropped.

Command outputs:
- o_runstop and o_clear are registered.
- Each asserts for exactly 1 cycle, starting the cycle after the triggering button edge.
- Never asserted together.

State transitions:
- IDLE: runstop -> RUN and pulse o_runstop. Clear and lap are ignored.
- RUN:
  - runstop -> STOP and pulse o_runstop.
  - lap -> capture {i_hour, i_min, i_sec, i_msec} as sampled on that edge into buf[wr_ptr].
  - On capture: wr_ptr++ (wraps at LAP_DEPTH); lap_cnt++ (saturates at LAP_DEPTH).
  - If full, see Optional Feature.
  - clear is ignored.
- STOP:
  - runstop -> RUN and pulse o_runstop.
  - clear -> IDLE, pulse o_clear, lap_cnt=0, wr_ptr=0, o_lap_idx=0.
  - lap -> REVIEW with o_lap_idx=0 only if lap_cnt>0; otherwise ignored.
- REVIEW:
  - lap -> o_lap_idx++; wraps to 0 after index lap_cnt-1.
  - runstop or clear -> STOP, o_lap_idx=0, no command pulse.
  - The stopwatch stays stopped throughout REVIEW.

Display path:
- In REVIEW: outputs show the entry at logical index o_lap_idx (index 0 = oldest stored lap). Combinational from the registered index/buffer, so it is valid in the same cycle the state/index register updates.
- In all other states: outputs equal the live inputs, combinationally.

Field widths are stored unchanged; no arithmetic on time fields.

Optional Feature:
Macro: LAP_OVERWRITE_EN.
- Defined: a lap taken while full overwrites the oldest entry. wr_ptr advances; the oldest pointer advances with it; lap_cnt stays LAP_DEPTH. Logical index 0 is always the oldest surviving lap.
- Undefined: a lap taken while full is dropped. The buffer and pointers are unchanged, and o_full stays 1.

Test Plan:
- Reset then runstop pulse -> next cycle o_runstop=1 for 1 cycle, o_state=01; a clear pulse in RUN -> o_clear stays 0, state stays 01.
- In RUN, lap with inputs 00:01:05.42 -> o_lap_cnt=1. Then runstop -> STOP; lap -> REVIEW, display reads hour=0, min=1, sec=5, msec=42.
- Capture 3 laps (A, B, C), then STOP, enter REVIEW, 3 more lap pulses -> o_lap_idx sequence 0,1,2,0; display follows A, B, C, A.
- Same-cycle clear+runstop in STOP -> o_clear pulse only, state=IDLE, o_lap_cnt=0; o_runstop never asserted.
- 5 laps (values 1..5 msec) with LAP_DEPTH=4:
  - Without LAP_OVERWRITE_EN: review shows 1,2,3,4 and o_full=1.
  - With LAP_OVERWRITE_EN: review shows 2,3,4,5 and o_lap_cnt=4.
- rst asserted mid-REVIEW, asynchronously between clock edges -> o_state=00, o_lap_cnt=0, display equals live inputs immediately, with no command pulse.

Source files
------------

// File: rtl/stopwatch_lap_ctrl.sv
// Mode/sequencing controller between debounced buttons and the stopwatch: run/stop/clear
// commands, lap capture into a ring buffer, and live/lap display mux. Option: LAP_OVERWRITE_EN.
module stopwatch_lap_ctrl #(
  parameter int LAP_DEPTH = 4,
  parameter int IDX_W     = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_btn_runstop,
  input  logic             i_btn_clear,
  input  logic             i_btn_lap,
  input  logic [6:0]       i_msec,
  input  logic [5:0]       i_sec,
  input  logic [5:0]       i_min,
  input  logic [4:0]       i_hour,
  output logic             o_runstop,
  output logic             o_clear,
  output logic [6:0]       o_disp_msec,
  output logic [5:0]       o_disp_sec,
  output logic [5:0]       o_disp_min,
  output logic [4:0]       o_disp_hour,
  output logic [IDX_W:0]   o_lap_cnt,
  output logic [IDX_W-1:0] o_lap_idx,
  output logic             o_full,
  output logic [1:0]       o_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_RUN    = 2'b01,
    S_STOP   = 2'b10,
    S_REVIEW = 2'b11
  } state_t;

  localparam logic [IDX_W:0]   DEPTH_C = (IDX_W+1)'(LAP_DEPTH);
  localparam logic [IDX_W-1:0] LAST_C  = (IDX_W)'(LAP_DEPTH - 1);

  state_t           r_state, w_state_nx;
  logic [IDX_W:0]   r_lap_cnt, w_lap_cnt_nx;
  logic [IDX_W-1:0] r_wr_ptr, w_wr_ptr_nx;
  logic [IDX_W-1:0] r_lap_idx, w_lap_idx_nx;
  logic             r_runstop, w_runstop_nx;
  logic             r_clear, w_clear_nx;
  logic             w_cap;
  logic [23:0]      r_buf [LAP_DEPTH];

  logic [23:0]      w_live;
  logic             w_full;
  logic [IDX_W-1:0] w_wr_ptr_inc;
  logic             w_idx_last;
  logic [IDX_W-1:0] w_oldest;
  logic [IDX_W:0]   w_rd_sum;
  logic [IDX_W:0]   w_rd_wide;
  logic [IDX_W-1:0] w_rd_ptr;
  logic [23:0]      w_disp;

  assign w_live       = {i_hour, i_min, i_sec, i_msec};
  assign w_full       = (r_lap_cnt == DEPTH_C);
  assign w_wr_ptr_inc = (r_wr_ptr == LAST_C) ? '0 : r_wr_ptr + 1'b1;
  assign w_idx_last   = ({1'b0, r_lap_idx} == (r_lap_cnt - 1'b1));

  // Oldest entry sits at wr_ptr once the ring is full, otherwise at slot 0.
  assign w_oldest  = w_full ? r_wr_ptr : '0;
  assign w_rd_sum  = {1'b0, w_oldest} + {1'b0, r_lap_idx};
  assign w_rd_wide = (w_rd_sum >= DEPTH_C) ? (w_rd_sum - DEPTH_C) : w_rd_sum;
  assign w_rd_ptr  = w_rd_wide[IDX_W-1:0];

  always_comb begin
    w_state_nx   = r_state;
    w_lap_cnt_nx = r_lap_cnt;
    w_wr_ptr_nx  = r_wr_ptr;
    w_lap_idx_nx = r_lap_idx;
    w_runstop_nx = 1'b0;
    w_clear_nx   = 1'b0;
    w_cap        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_btn_runstop) begin
          w_state_nx   = S_RUN;
          w_runstop_nx = 1'b1;
        end
      end
      S_RUN: begin
        if (i_btn_runstop) begin
          w_state_nx   = S_STOP;
          w_runstop_nx = 1'b1;
        end else if (i_btn_lap) begin
`ifdef LAP_OVERWRITE_EN
          w_cap       = 1'b1;
          w_wr_ptr_nx = w_wr_ptr_inc;
          if (!w_full) w_lap_cnt_nx = r_lap_cnt + 1'b1;
`else
          if (!w_full) begin
            w_cap        = 1'b1;
            w_wr_ptr_nx  = w_wr_ptr_inc;
            w_lap_cnt_nx = r_lap_cnt + 1'b1;
          end
`endif
        end
      end
      S_STOP: begin
        if (i_btn_clear) begin
          w_state_nx   = S_IDLE;
          w_clear_nx   = 1'b1;
          w_lap_cnt_nx = '0;
          w_wr_ptr_nx  = '0;
          w_lap_idx_nx = '0;
        end else if (i_btn_runstop) begin
          w_state_nx   = S_RUN;
          w_runstop_nx = 1'b1;
        end else if (i_btn_lap && (r_lap_cnt != '0)) begin
          w_state_nx   = S_REVIEW;
          w_lap_idx_nx = '0;
        end
      end
      S_REVIEW: begin
        // Leaving review never commands the stopwatch; it was already stopped.
        if (i_btn_runstop || i_btn_clear) begin
          w_state_nx   = S_STOP;
          w_lap_idx_nx = '0;
        end else if (i_btn_lap) begin
          w_lap_idx_nx = w_idx_last ? '0 : r_lap_idx + 1'b1;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_lap_cnt <= '0;
      r_wr_ptr  <= '0;
      r_lap_idx <= '0;
      r_runstop <= 1'b0;
      r_clear   <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_lap_cnt <= w_lap_cnt_nx;
      r_wr_ptr  <= w_wr_ptr_nx;
      r_lap_idx <= w_lap_idx_nx;
      r_runstop <= w_runstop_nx;
      r_clear   <= w_clear_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (w_cap) r_buf[r_wr_ptr] <= w_live;
  end

  assign w_disp = (r_state == S_REVIEW) ? r_buf[w_rd_ptr] : w_live;

  assign o_disp_msec = w_disp[6:0];
  assign o_disp_sec  = w_disp[12:7];
  assign o_disp_min  = w_disp[18:13];
  assign o_disp_hour = w_disp[23:19];
  assign o_runstop   = r_runstop;
  assign o_clear     = r_clear;
  assign o_lap_cnt   = r_lap_cnt;
  assign o_lap_idx   = r_lap_idx;
  assign o_full      = w_full;
  assign o_state     = r_state;

endmodule
